// File: rtl/pad_debounce_ctrl.sv
// Pad input conditioner: 2-flop synchroniser, tick-sampled debouncer, edge pulses and
// per-channel interrupt-pending flags combined into a single IRQ line.
module pad_debounce_ctrl #(
    parameter int NUM_PINS     = 4,
    parameter int SAMPLE_DIV   = 1000,
    parameter int STABLE_COUNT = 4
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic [NUM_PINS-1:0] PAD_IN,
    input  logic [NUM_PINS-1:0] IRQ_EN,
    input  logic [NUM_PINS-1:0] IRQ_EDGE,
    input  logic [NUM_PINS-1:0] IRQ_CLR,
    output logic [NUM_PINS-1:0] DB_OUT,
    output logic [NUM_PINS-1:0] RISE,
    output logic [NUM_PINS-1:0] FALL,
    output logic [NUM_PINS-1:0] IRQ_PENDING,
    output logic                IRQ
);

    localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CW = $clog2(STABLE_COUNT + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_COUNT - 1);

    logic [NUM_PINS-1:0] r_sync1;
    logic [NUM_PINS-1:0] r_sync2;
    logic [TW-1:0]       r_tick_cnt;
    logic [CW-1:0]       r_stab [NUM_PINS];
    logic [NUM_PINS-1:0] r_db;
    logic [NUM_PINS-1:0] r_rise;
    logic [NUM_PINS-1:0] r_fall;
    logic [NUM_PINS-1:0] r_pend;

    logic                w_tick;
    logic [NUM_PINS-1:0] w_diff;
    logic [NUM_PINS-1:0] w_accept;
    logic [NUM_PINS-1:0] w_pend_set;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= PAD_IN;
            r_sync2 <= r_sync1;
        end
    end

    // With SAMPLE_DIV == 1 the counter stays at 0 and the tick is permanently high.
    assign w_tick = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    assign w_diff = r_sync2 ^ r_db;

    always_comb begin
        w_accept = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            w_accept[i] = w_tick && w_diff[i] && (r_stab[i] == CNT_LAST);
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int i = 0; i < NUM_PINS; i++) begin
                r_stab[i] <= '0;
            end
        end else if (w_tick) begin
            for (int i = 0; i < NUM_PINS; i++) begin
                if (!w_diff[i] || w_accept[i]) begin
                    r_stab[i] <= '0;
                end else begin
                    r_stab[i] <= r_stab[i] + CW'(1);
                end
            end
        end
    end

    // Edge pulses line up with the first cycle of the new debounced level.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_db   <= '0;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_db   <= r_db ^ w_accept;
            r_rise <= w_accept & ~r_db;
            r_fall <= w_accept & r_db;
        end
    end

    assign w_pend_set = IRQ_EN & ((IRQ_EDGE & r_rise) | (~IRQ_EDGE & r_fall));

    // Set has priority over a simultaneous clear.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~IRQ_CLR) | w_pend_set;
        end
    end

    assign DB_OUT      = r_db;
    assign RISE        = r_rise;
    assign FALL        = r_fall;
    assign IRQ_PENDING = r_pend;
    assign IRQ         = |r_pend;

endmodule
